// File: rtl/i2c_slave.sv
// I2C target: synchronises scl/sda, detects START/STOP, matches a 7-bit address,
// ACKs writes into dat_out and serves reads from dat_in. It never stretches scl.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1111000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] dat_in,
  output logic [7:0] dat_out,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       r_w
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic                   r_sda_oe, w_sda_oe_nxt;
  logic [7:0]             r_dat_out, w_dat_out_nxt;
  logic                   r_rx_valid, w_rx_valid_nxt;
  logic                   r_tx_req, w_tx_req_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_rw, w_rw_nxt;

  logic w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;

  // Open drain: only ever pull low, the external pull-up supplies the high level.
  assign sda = r_sda_oe ? 1'b0 : 1'bz;

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s &  r_scl_d;
  assign w_start    =  w_scl_s &  r_scl_d & ~w_sda_s &  r_sda_d;
  assign w_stop     =  w_scl_s &  r_scl_d &  w_sda_s & ~r_sda_d;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sda_oe   <= 1'b0;
      r_dat_out  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_dat_out  <= w_dat_out_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_busy     <= w_busy_nxt;
      r_rw       <= w_rw_nxt;
    end
  end

  // NOTE: every signal gets its hold/idle value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_sda_oe_nxt   = r_sda_oe;
    w_dat_out_nxt  = r_dat_out;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_busy_nxt     = r_busy;
    w_rw_nxt       = r_rw;

    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_busy_nxt   = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_cnt_nxt    = '0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_sda_oe_nxt = 1'b0;
      w_cnt_nxt    = '0;
      w_shift_nxt  = '0;
    end else begin
      case (r_state)
        S_ADDR: if (w_scl_rise) begin
          w_shift_nxt = {r_shift[6:0], w_sda_s};
          if (r_cnt == 4'd7) begin
            w_cnt_nxt = '0;
            if (r_shift[6:0] == SLAVE_ADDR) begin
              w_rw_nxt    = w_sda_s;
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_ADDR_ACK;
            end else begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_WAIT_STOP;
            end
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        // First fall starts the ACK pulse; the second fall ends the 9th clock.
        S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
          if (!r_sda_oe) begin
            w_sda_oe_nxt = 1'b1;
          end else begin
            w_cnt_nxt = '0;
            if (r_rw) begin
              w_tx_req_nxt = 1'b1;
              w_shift_nxt  = dat_in;
              w_sda_oe_nxt = ~dat_in[7];
              w_state_nxt  = S_RD_DATA;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: if (w_scl_rise) begin
          w_shift_nxt = {r_shift[6:0], w_sda_s};
          if (r_cnt == 4'd7) begin
            w_dat_out_nxt  = {r_shift[6:0], w_sda_s};
            w_rx_valid_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_WR_ACK;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        S_RD_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_RD_ACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        // r_cnt==9 marks a received master ACK awaiting the reload fall.
        S_RD_ACK: begin
          if (w_scl_rise && r_cnt == 4'd8) begin
            if (w_sda_s) w_state_nxt = S_WAIT_STOP;
            else         w_cnt_nxt   = 4'd9;
          end else if (w_scl_fall && r_cnt == 4'd9) begin
            w_tx_req_nxt = 1'b1;
            w_shift_nxt  = dat_in;
            w_sda_oe_nxt = ~dat_in[7];
            w_cnt_nxt    = '0;
            w_state_nxt  = S_RD_DATA;
          end
        end
        default: w_sda_oe_nxt = 1'b0;
      endcase
    end
  end

  assign dat_out  = r_dat_out;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;
  assign r_w      = r_rw;

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) matching the team's `i2cmaster`; sits on the same `sda`/`scl` pair.
- Oversamples `scl`/`sda` on the system clock, detects START/STOP, and matches its 7-bit address.
- ACKs address and write bytes; presents written bytes on `dat_out`; serves read bytes from `dat_in`.
- Supports multi-byte transfers and repeated START.

Parameters:
- SLAVE_ADDR, 7'b1111000, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchronizer flops on `scl` and `sda` inputs (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock from master; asynchronous to `clk`.
- sda  inout  1  I2C data, open-drain: driven 0 when `sda_oe`=1, else 1'bz; external pull-up.
- dat_in  input  8  read data; sampled when `tx_req` pulses.
- dat_out  output  8  last byte written by master.
- rx_valid  output  1  1-cycle pulse: `dat_out` updated.
- tx_req  output  1  1-cycle pulse: `dat_in` captured into TX shifter.
- busy  output  1  high from addressed START until STOP or return to IDLE.
- r_w  output  1  R/W bit of the current addressed transaction (1 = read).

Behaviour:
- Reset: all outputs 0, `sda` released (z), state IDLE, shifters and bit counter cleared. Reset mid-transfer releases `sda` the same cycle reset is sampled, and waits for the next START.
- Input path: `scl` and `sda` pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - Pin edge to internal event latency: SYNC_STAGES+1 clk.
  - Requires each `scl` high/low phase ≥ SYNC_STAGES+2 clk.
- START: synced `sda` falls while synced `scl`=1. Valid in any state, including repeated START mid-transfer. Goes to ADDR, bit count 0, `sda` released.
- STOP: synced `sda` rises while synced `scl`=1. From any state goes to IDLE; `busy`=0 and `sda` released next clk.
- Sampling: bits are sampled on synced `scl` rising edge. `sda` drive changes only on synced `scl` falling edge. Bits are MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th rising edge compare `[7:1]` with SLAVE_ADDR.
    - Match: latch `r_w`, `busy`=1, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP, never drive `sda`.
  - ADDR_ACK: on the next `scl` fall drive `sda`=0 through the 9th clock; release on the following fall.
    - If `r_w`=0: go to WR_DATA.
    - If `r_w`=1: at the same fall pulse `tx_req`, load `dat_in`, drive bit 7, go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th rising edge, `dat_out`←byte and `rx_valid` pulses one clk. Go to WR_ACK.
  - WR_ACK: ACK exactly as in ADDR_ACK, then back to WR_DATA. Unlimited byte count.
  - RD_DATA: drive next bit on each `scl` fall; a 0 bit drives low, a 1 bit releases. After bit 0's clock high phase, release on the fall and go to RD_ACK.
  - RD_ACK: sample master ACK on the 9th rising edge.
    - ACK (0): on the next fall pulse `tx_req`, reload from `dat_in`, go to RD_DATA.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: `sda` released; leave only on STOP or START.
- STOP or START in the middle of a byte aborts the byte: no `rx_valid` for a partial byte; the shifter is discarded.
- The target never stretches `scl` and never drives `sda` high.

Test Plan:
1. Addressed write: master START, addr 7'b1111000, W, data 8'hFF, STOP.
   - `sda`=0 during both 9th clocks.
   - `rx_valid` pulses once with `dat_out`=8'hFF.
   - `busy` falls ≤ SYNC_STAGES+2 clk after STOP.
2. Address mismatch: addr 7'h12, W, data 8'h3C.
   - `sda` never driven (master sees NACK); `busy`, `rx_valid`, `tx_req` stay 0; state IDLE after STOP.
3. Read with `dat_in`=8'hA5, master NACK.
   - Master receives 1010_0101; `tx_req` pulses once; `sda` released after the 8th bit; no further drive until STOP.
4. Two-byte read, `dat_in`=8'h5A then 8'hC3, master ACK then NACK.
   - Master receives 8'h5A, 8'hC3; `tx_req` pulses twice.
5. Repeated START: write 8'h11, then Sr, addr 7'b1111000, R with `dat_in`=8'h80.
   - `dat_out`=8'h11; `r_w` flips 0→1; master reads 8'h80; `busy` stays 1 across Sr.
6. Reset mid-write after 4 data bits.
   - `sda`=z and all outputs 0 next clk; no `rx_valid`.
   - A later full write of 8'h42 is received correctly.
